d_reg_slave: RTL and testbench
==============================

D_REG_SLAVE -- requirements
Module: d_reg_slave

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; only 32 is supported.
REQ-002 SHALL have parameter PRESCALE_DIV, default 4, number of clk cycles per timer tick; legal range is 1..256.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstb, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port reg_addr, input, 16 bits: byte offset; bits [1:0] are ignored.
REQ-006 SHALL have port reg_wr_en, input, 1 bit: single-cycle write strobe.
REQ-007 SHALL have port reg_wr_be, input, XLEN/8 bits: byte enables.
REQ-008 SHALL have port reg_wr_data, input, XLEN bits: write data.
REQ-009 SHALL have port reg_rd_en, input, 1 bit: single-cycle read strobe.
REQ-010 SHALL have port reg_rd_data, output, XLEN bits: read data.
REQ-011 SHALL have port reg_rd_ready, output, 1 bit: read data valid.
REQ-012 SHALL have port gpio_out, output, 8 bits: general-purpose outputs.
REQ-013 SHALL have port timer_irq, output, 1 bit: machine timer interrupt.

Function
REQ-014 SHALL implement this register map (offset name access reset):
- 0x00 ID, RO, 0x58525631.
- 0x04 SCRATCH, RW, 0.
- 0x08 GPIO, RW [7:0], 0.
- 0x0C MTIME_LO, RW, 0.
- 0x10 MTIME_HI, RW, 0.
- 0x14 MTIMECMP_LO, RW, 0xFFFFFFFF.
- 0x18 MTIMECMP_HI, RW, 0xFFFFFFFF.
- 0x1C CTRL, RW [1:0], 0; bit0 = timer enable, bit1 = irq enable.
REQ-015 SHALL return 0 on reads of unmapped offsets or unused bits, and SHALL ignore writes to them and to ID.
REQ-016 SHALL update a write only in the bytes whose reg_wr_be bit is set; the new value is visible from the next cycle.
REQ-017 SHALL assert reg_rd_ready for exactly one cycle, the cycle after reg_rd_en, with reg_rd_data valid in that cycle; reg_rd_data SHALL hold its value until the next read completes.
REQ-018 SHALL, when read and write target the same offset in the same cycle, return the pre-write value.
REQ-019 SHALL, on a read of MTIME_LO, capture MTIME_HI into a shadow register in the same cycle; reads of MTIME_HI SHALL return the shadow, giving atomic 64-bit lo-then-hi reads.
REQ-020 SHALL run a prescaler that counts 0..PRESCALE_DIV-1 while CTRL.bit0 = 1, and SHALL hold it at 0 while CTRL.bit0 = 0.
REQ-021 SHALL increment the 64-bit mtime by 1 on each prescaler wrap, with carry from LO to HI; 0xFFFF_FFFF_FFFF_FFFF SHALL wrap to 0.
REQ-022 SHALL, when a write to MTIME_LO or MTIME_HI coincides with an increment, take the written value and drop that increment.
REQ-023 SHALL register timer_irq as CTRL.bit1 AND (mtime >= mtimecmp), using an unsigned 64-bit compare; timer_irq SHALL deassert the cycle after the condition clears.
REQ-024 SHALL drive gpio_out directly from the GPIO register.

Reset
REQ-025 SHALL, while rstb = 0, asynchronously set every register to its REQ-014 reset value, the shadow and prescaler to 0, and reg_rd_data, reg_rd_ready, gpio_out and timer_irq to 0.
REQ-026 SHALL drop a read in flight when reset is asserted: reg_rd_ready is 0 after reset deasserts.

Configuration
REQ-027 SHALL, with macro DREG_TIMER_EN defined, implement the timer, offsets 0x0C-0x1C, and timer_irq.
REQ-028 SHALL, without DREG_TIMER_EN, remove the prescaler, mtime, mtimecmp and CTRL logic; offsets 0x0C-0x1C SHALL read 0 and ignore writes; timer_irq SHALL be tied to 0.

Verification
REQ-029 Reset, then read 0x00 -> reg_rd_ready = 1 exactly one cycle later, reg_rd_data = 0x58525631.
REQ-030 Write 0x04 = 0xAABBCCDD with be = 4'b0101 after reset -> read 0x04 returns 0x00BB00DD.
REQ-031 PRESCALE_DIV = 4, CTRL = 1, 40 cycles -> mtime = 10 ±1; read of ID and read of 0x40 in the same window -> 0x40 returns 0.
REQ-032 mtime = 0x00000000_FFFFFFFF, enabled, read LO just before the carry, then read HI after the carry -> HI returns 0 (shadow), and a fresh LO/HI read pair returns HI = 1.
REQ-033 mtimecmp = 20, CTRL = 3 -> timer_irq rises one cycle after mtime reaches 20; write MTIMECMP_HI = 1 -> timer_irq falls.
REQ-034 Assert rstb low during a pending read with CTRL = 3 -> all outputs 0 immediately, no reg_rd_ready after release, MTIMECMP reads 0xFFFFFFFF.

Source files
------------

// File: rtl/d_reg_slave.sv
// rtl/d_reg_slave.sv - register slave: ID, scratch, GPIO and an optional 64-bit machine timer
// Timer registers (0x0C-0x1C), prescaler and timer_irq exist only when DREG_TIMER_EN is defined.
module d_reg_slave #(
  parameter int XLEN         = 32,
  parameter int PRESCALE_DIV = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [15:0]       reg_addr,
  input  logic              reg_wr_en,
  input  logic [XLEN/8-1:0] reg_wr_be,
  input  logic [XLEN-1:0]   reg_wr_data,
  input  logic              reg_rd_en,
  output logic [XLEN-1:0]   reg_rd_data,
  output logic              reg_rd_ready,
  output logic [7:0]        gpio_out,
  output logic              timer_irq
);

  localparam logic [31:0] ID_VALUE     = 32'h5852_5631;
  localparam logic [2:0]  OFS_ID       = 3'd0;
  localparam logic [2:0]  OFS_SCRATCH  = 3'd1;
  localparam logic [2:0]  OFS_GPIO     = 3'd2;
  localparam logic [2:0]  OFS_MTIME_LO = 3'd3;
  localparam logic [2:0]  OFS_MTIME_HI = 3'd4;
  localparam logic [2:0]  OFS_CMP_LO   = 3'd5;
  localparam logic [2:0]  OFS_CMP_HI   = 3'd6;
  localparam logic [2:0]  OFS_CTRL     = 3'd7;

  if (XLEN != 32) begin : g_bad_xlen
    $error("d_reg_slave: only XLEN = 32 is supported");
  end
  if (PRESCALE_DIV < 1 || PRESCALE_DIV > 256) begin : g_bad_prescale
    $error("d_reg_slave: PRESCALE_DIV must be 1..256");
  end

  function automatic logic [XLEN-1:0] be_merge(input logic [XLEN-1:0]   old_val,
                                               input logic [XLEN-1:0]   new_val,
                                               input logic [XLEN/8-1:0] be);
    logic [XLEN-1:0] r;
    r = old_val;
    for (int b = 0; b < XLEN/8; b++)
      if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
    return r;
  endfunction

  // Only the first 32 bytes are mapped; anything with upper address bits set reads 0.
  logic       mapped;
  logic [2:0] idx;
  logic [7:0] wr_hit;
  logic       rd_lo_hit;

  assign mapped    = (reg_addr[15:5] == 11'd0);
  assign idx       = reg_addr[4:2];
  assign rd_lo_hit = reg_rd_en && mapped && (idx == OFS_MTIME_LO);

  always_comb begin
    wr_hit = '0;
    if (reg_wr_en && mapped) wr_hit[idx] = 1'b1;
  end

  logic [XLEN-1:0] scratch_q;
  logic [7:0]      gpio_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      scratch_q <= '0;
      gpio_q    <= '0;
    end else begin
      if (wr_hit[OFS_SCRATCH]) scratch_q <= be_merge(scratch_q, reg_wr_data, reg_wr_be);
      if (wr_hit[OFS_GPIO] && reg_wr_be[0]) gpio_q <= reg_wr_data[7:0];
    end
  end

  assign gpio_out = gpio_q;

`ifdef DREG_TIMER_EN
  localparam int            PW      = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE_DIV - 1);

  logic [PW-1:0]   presc_q;
  logic [XLEN-1:0] mtime_lo;
  logic [XLEN-1:0] mtime_hi;
  logic [XLEN-1:0] cmp_lo;
  logic [XLEN-1:0] cmp_hi;
  logic [XLEN-1:0] shadow_hi;
  logic [1:0]      ctrl_q;
  logic            mtime_tick;
  logic [63:0]     mtime_inc;
  logic            unused_ok;

  assign mtime_tick = ctrl_q[0] && (presc_q == PS_LAST);
  assign mtime_inc  = {mtime_hi, mtime_lo} + 64'd1;
  assign unused_ok  = ^{reg_addr[1:0], wr_hit[0]};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      presc_q   <= '0;
      mtime_lo  <= '0;
      mtime_hi  <= '0;
      cmp_lo    <= '1;
      cmp_hi    <= '1;
      shadow_hi <= '0;
      ctrl_q    <= '0;
      timer_irq <= 1'b0;
    end else begin
      if (!ctrl_q[0] || mtime_tick) presc_q <= '0;
      else                          presc_q <= presc_q + 1'b1;

      // A software write to either half wins; the coincident increment is lost.
      if (wr_hit[OFS_MTIME_LO])      mtime_lo <= be_merge(mtime_lo, reg_wr_data, reg_wr_be);
      else if (wr_hit[OFS_MTIME_HI]) mtime_hi <= be_merge(mtime_hi, reg_wr_data, reg_wr_be);
      else if (mtime_tick)           {mtime_hi, mtime_lo} <= mtime_inc;

      if (wr_hit[OFS_CMP_LO]) cmp_lo <= be_merge(cmp_lo, reg_wr_data, reg_wr_be);
      if (wr_hit[OFS_CMP_HI]) cmp_hi <= be_merge(cmp_hi, reg_wr_data, reg_wr_be);
      if (wr_hit[OFS_CTRL] && reg_wr_be[0]) ctrl_q <= reg_wr_data[1:0];

      if (rd_lo_hit) shadow_hi <= mtime_hi;
      timer_irq <= ctrl_q[1] && ({mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo});
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{reg_addr[1:0], wr_hit[0], wr_hit[7:3], rd_lo_hit};
  assign timer_irq = 1'b0;
`endif

  logic [XLEN-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (mapped) begin
      case (idx)
        OFS_ID:       rd_mux = ID_VALUE;
        OFS_SCRATCH:  rd_mux = scratch_q;
        OFS_GPIO:     rd_mux = {{(XLEN-8){1'b0}}, gpio_q};
`ifdef DREG_TIMER_EN
        OFS_MTIME_LO: rd_mux = mtime_lo;
        OFS_MTIME_HI: rd_mux = shadow_hi;
        OFS_CMP_LO:   rd_mux = cmp_lo;
        OFS_CMP_HI:   rd_mux = cmp_hi;
        OFS_CTRL:     rd_mux = {{(XLEN-2){1'b0}}, ctrl_q};
`endif
        default:      rd_mux = '0;
      endcase
    end
  end

  // Read data is sampled from pre-write state, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      reg_rd_data  <= '0;
      reg_rd_ready <= 1'b0;
    end else begin
      reg_rd_ready <= reg_rd_en;
      if (reg_rd_en) reg_rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_d_reg_slave.sv
// tb/tb_d_reg_slave.sv - self-checking bench for d_reg_slave (timer checks when DREG_TIMER_EN is defined)
module tb_d_reg_slave;

  localparam logic [31:0] ID = 32'h5852_5631;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic [15:0] reg_addr = '0;
  logic        reg_wr_en = 1'b0;
  logic [3:0]  reg_wr_be = '0;
  logic [31:0] reg_wr_data = '0;
  logic        reg_rd_en = 1'b0;
  logic [31:0] reg_rd_data;
  logic        reg_rd_ready;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  always #5 clk = ~clk;

  d_reg_slave #(.XLEN(32), .PRESCALE_DIV(4)) dut (
    .clk(clk), .rstb(rstb), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en),
    .reg_wr_be(reg_wr_be), .reg_wr_data(reg_wr_data), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .reg_rd_ready(reg_rd_ready), .gpio_out(gpio_out),
    .timer_irq(timer_irq)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic was_rd;
    was_rd = reg_rd_en;
    @(posedge clk);
    #1;
    reg_rd_en = 1'b0;
    reg_wr_en = 1'b0;
    check("rd_ready", {31'd0, reg_rd_ready}, {31'd0, was_rd});
    if (was_rd && exp_q.size() > 0) check("rd_data", reg_rd_data, exp_q.pop_front());
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    reg_addr = a; reg_wr_be = be; reg_wr_data = d; reg_wr_en = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e);
    reg_addr = a; reg_rd_en = 1'b1; exp_q.push_back(e);
    tick();
  endtask

  task automatic rd_val(input logic [15:0] a, output logic [31:0] v);
    reg_addr = a; reg_rd_en = 1'b1;
    tick();
    v = reg_rd_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int first;

    vt[0]  = '{1'b0, 1'b1, 16'h0000, 4'h0, 32'h0,         ID};
    vt[1]  = '{1'b1, 1'b0, 16'h0004, 4'h5, 32'hAABBCCDD,  32'h0};
    vt[2]  = '{1'b0, 1'b1, 16'h0004, 4'h0, 32'h0,         32'h00BB00DD};
    vt[3]  = '{1'b1, 1'b0, 16'h0000, 4'hF, 32'hFFFFFFFF,  32'h0};
    vt[4]  = '{1'b0, 1'b1, 16'h0000, 4'h0, 32'h0,         ID};
    vt[5]  = '{1'b1, 1'b0, 16'h0008, 4'hF, 32'h12345678,  32'h0};
    vt[6]  = '{1'b0, 1'b1, 16'h0008, 4'h0, 32'h0,         32'h00000078};
    vt[7]  = '{1'b1, 1'b0, 16'h0040, 4'hF, 32'hDEADBEEF,  32'h0};
    vt[8]  = '{1'b0, 1'b1, 16'h0040, 4'h0, 32'h0,         32'h0};
    vt[9]  = '{1'b0, 1'b1, 16'h0003, 4'h0, 32'h0,         ID};
    vt[10] = '{1'b1, 1'b0, 16'h0004, 4'hA, 32'h11223344,  32'h0};
    vt[11] = '{1'b0, 1'b1, 16'h0004, 4'h0, 32'h0,         32'h11BB33DD};
    vt[12] = '{1'b1, 1'b1, 16'h0004, 4'hF, 32'h00000055,  32'h11BB33DD};
    vt[13] = '{1'b0, 1'b1, 16'h0004, 4'h0, 32'h0,         32'h00000055};
    vt[14] = '{1'b0, 1'b1, 16'h0104, 4'h0, 32'h0,         32'h0};
    vt[15] = '{1'b1, 1'b0, 16'h0008, 4'hE, 32'h000000AA,  32'h0};
    vt[16] = '{1'b0, 1'b1, 16'h0008, 4'h0, 32'h0,         32'h00000078};

    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_ready", {31'd0, reg_rd_ready}, 32'd0);
    check("reset_rd_data", reg_rd_data, 32'd0);
    check("reset_gpio", {24'd0, gpio_out}, 32'd0);
    check("reset_irq", {31'd0, timer_irq}, 32'd0);
    #2 rstb = 1'b1;

    for (int i = 0; i < 17; i++) begin
      reg_addr = vt[i].addr; reg_wr_en = vt[i].wr; reg_wr_be = vt[i].be;
      reg_wr_data = vt[i].data; reg_rd_en = vt[i].rd;
      if (vt[i].rd) exp_q.push_back(vt[i].exp);
      tick();
    end
    tick();
    check("rd_data_hold", reg_rd_data, 32'h00000078);
    check("gpio_out", {24'd0, gpio_out}, 32'h00000078);

`ifdef DREG_TIMER_EN
    // Free-running count: about 10 ticks in 40 cycles.
    wr(16'h001C, 4'hF, 32'd1);
    rd(16'h0000, ID);
    rd(16'h0040, 32'd0);
    repeat (36) tick();
    rd_val(16'h000C, v);
    total++;
    if (v < 32'd9 || v > 32'd11) begin
      bad++;
      $display("FAIL mtime_40cyc: got %0d expected 9..11", v);
    end

    // LO/HI shadow across the 32-bit carry.
    wr(16'h001C, 4'hF, 32'd0);
    wr(16'h000C, 4'hF, 32'hFFFFFFFF);
    wr(16'h0010, 4'hF, 32'd0);
    wr(16'h001C, 4'hF, 32'd1);
    rd(16'h000C, 32'hFFFFFFFF);
    repeat (4) tick();
    rd(16'h0010, 32'd0);
    rd(16'h000C, 32'd0);
    rd(16'h0010, 32'd1);

    // Compare interrupt at mtime = 20.
    wr(16'h001C, 4'hF, 32'd0);
    wr(16'h000C, 4'hF, 32'd0);
    wr(16'h0010, 4'hF, 32'd0);
    wr(16'h0014, 4'hF, 32'd20);
    wr(16'h0018, 4'hF, 32'd0);
    wr(16'h001C, 4'hF, 32'd3);
    first = 0;
    for (int i = 1; i <= 200 && first == 0; i++) begin
      tick();
      if (timer_irq) first = i;
    end
    check("irq_rise_cycle", first, 32'd81);
    wr(16'h0018, 4'hF, 32'd1);
    check("irq_hold_one_cycle", {31'd0, timer_irq}, 32'd1);
    tick();
    check("irq_fall", {31'd0, timer_irq}, 32'd0);
    wr(16'h0018, 4'hF, 32'd0);
    tick();
    check("irq_rearm", {31'd0, timer_irq}, 32'd1);
`else
    for (int a = 'h0C; a <= 'h1C; a += 4) wr(16'(a), 4'hF, 32'hFFFFFFFF);
    for (int a = 'h0C; a <= 'h1C; a += 4) rd(16'(a), 32'd0);
    check("irq_tied_low", {31'd0, timer_irq}, 32'd0);
`endif

    // Reset with a completed read showing and a new one pending.
    rd(16'h0000, ID);
    reg_addr = 16'h0000; reg_rd_en = 1'b1;
    #2 rstb = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, reg_rd_ready}, 32'd0);
    check("async_rst_data", reg_rd_data, 32'd0);
    check("async_rst_gpio", {24'd0, gpio_out}, 32'd0);
    check("async_rst_irq", {31'd0, timer_irq}, 32'd0);
    reg_rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #3 rstb = 1'b1;
    @(posedge clk);
    #1;
    check("no_ready_after_rst", {31'd0, reg_rd_ready}, 32'd0);
    rd(16'h0004, 32'd0);
`ifdef DREG_TIMER_EN
    rd(16'h0014, 32'hFFFFFFFF);
    rd(16'h0018, 32'hFFFFFFFF);
    rd(16'h001C, 32'd0);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
